data_io_dma: RTL and testbench

- Next-generation IO-controller download client: SPI slave oversampled in the system clock domain, decoding file-transfer commands and streaming downloaded bytes to an external memory write port (SDRAM/BRAM arbiter) through a req/ack handshake.
- Generalises the fixed 8-bit, 14-bit-address RAM loader with:
  - parametrised address and data width
  - byte packing with byte enables
  - file index capture
  - write back-pressure and overrun detection
- Sits between the top-level SPI pins and the core's memory controller.

---
 rtl/data_io_dma_if.sv | 32 +++
 rtl/data_io_dma.sv | 274 +++++++++++++++++++++++++++
 tb/tb_data_io_dma.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/data_io_dma_if.sv
// Memory write port of the data_io_dma download client.
//   master (DUT side): drives wr_req, wr_addr, wr_data, wr_be; samples wr_ack
//   slave (memory/arbiter side): the reverse
// A write is accepted in any cycle where wr_req && wr_ack.
interface data_io_dma_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) ();
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  wr_req;
    logic                  wr_ack;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        output wr_be,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        input  wr_be,
        output wr_ack
    );
endinterface

// File: rtl/data_io_dma.sv
// IO-controller download client. Oversamples an SPI slave in the clk domain,
// decodes file-transfer commands and streams downloaded bytes, packed into
// DATA_WIDTH words with byte enables, to a memory write port.
// Ports:
//   clk, reset    system clock (>= 4x sck), asynchronous active-high reset
//   sck, ss, sdi  asynchronous SPI pins (ss high = deselected, MSB first)
//   downloading   download in progress
//   index         file index from the last FILE_INDEX command
//   size          bytes accepted in current/last download (saturating)
//   overrun       sticky: a completed word was dropped (cleared by start)
//   wr            memory write port (req/ack, addr, data, byte enables)
module data_io_dma #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int START_ADDR = 0,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 ss,
    input  logic                 sdi,
    output logic                 downloading,
    output logic [7:0]           index,
    output logic [23:0]          size,
    output logic                 overrun,
    data_io_dma_if.master        wr
);
    localparam int LANE_W = (BE_WIDTH > 1) ? $clog2(BE_WIDTH) : 1;

    localparam logic [7:0] CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // input synchronisers
    logic sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
    logic ss_meta_q, ss_meta_d, ss_sync_q, ss_sync_d;
    logic sdi_meta_q, sdi_meta_d, sdi_sync_q, sdi_sync_d;

    // SPI framing
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] cmd_q, cmd_d;
    logic       first_q, first_d;

    // download state
    logic [1:0]            state_q, state_d;
    logic [7:0]            index_q, index_d;
    logic [23:0]           size_q, size_d;
    logic                  overrun_q, overrun_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // word assembly
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [BE_WIDTH-1:0]   fill_q, fill_d;
    logic [LANE_W-1:0]     lane_q, lane_d;

    // holding register
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [BE_WIDTH-1:0]   wr_be_q, wr_be_d;

    // combinational events
    logic                  bit_edge, byte_done, first_data;
    logic [7:0]            rx_byte;
    logic                  ev_start, ev_end, ev_index, ev_data;
    logic [DATA_WIDTH-1:0] merged, word_data;
    logic [BE_WIDTH-1:0]   word_be;
    logic                  word_valid, hold_free, load;

    always_comb begin
        sck_meta_d = sck;
        sck_sync_d = sck_meta_q;
        sck_prev_d = sck_sync_q;
        ss_meta_d  = ss;
        ss_sync_d  = ss_meta_q;
        sdi_meta_d = sdi;
        sdi_sync_d = sdi_meta_q;

        bit_edge   = sck_sync_q && !sck_prev_q && !ss_sync_q;
        rx_byte    = {shift_q, sdi_sync_q};
        byte_done  = bit_edge && (bit_cnt_q == 4'd15);
        first_data = byte_done && first_q;

        // counter runs 0..7 for the command, then cycles 8..15 per data byte
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cmd_d     = cmd_q;
        first_d   = first_q;
        if (ss_sync_q) begin
            bit_cnt_d = '0;
            cmd_d     = '0;
            first_d   = 1'b0;
        end else if (bit_edge) begin
            shift_d = rx_byte[6:0];
            if (bit_cnt_q == 4'd7) begin
                cmd_d   = rx_byte;
                first_d = 1'b1;
            end
            if (byte_done) begin
                first_d = 1'b0;
            end
            bit_cnt_d = byte_done ? 4'd8 : bit_cnt_q + 4'd1;
        end

        ev_start = first_data && (cmd_q == CMD_FILE_TX) && rx_byte[0];
        ev_end   = first_data && (cmd_q == CMD_FILE_TX) && !rx_byte[0];
        ev_index = first_data && (cmd_q == CMD_FILE_INDEX);
        ev_data  = byte_done && (cmd_q == CMD_FILE_TX_DAT) && (state_q != ST_IDLE);

        // byte packing, lane 0 first; a finished or flushed word leaves the
        // assembly zeroed so unfilled lanes of a partial word read as 0
        merged = asm_q;
        merged[int'(lane_q)*8 +: 8] = rx_byte;
        asm_d      = asm_q;
        fill_d     = fill_q;
        lane_d     = lane_q;
        word_valid = 1'b0;
        word_data  = asm_q;
        word_be    = fill_q;
        if (ev_start) begin
            asm_d  = '0;
            fill_d = '0;
            lane_d = '0;
        end else if (ev_data) begin
            if (lane_q == LANE_W'(BE_WIDTH - 1)) begin
                word_valid = 1'b1;
                word_data  = merged;
                word_be    = '1;
                asm_d      = '0;
                fill_d     = '0;
                lane_d     = '0;
            end else begin
                asm_d          = merged;
                fill_d[lane_q] = 1'b1;
                lane_d         = lane_q + LANE_W'(1);
            end
        end else if (ev_end && (fill_q != '0)) begin
            word_valid = 1'b1;
            word_data  = asm_q;
            word_be    = fill_q;
            asm_d      = '0;
            fill_d     = '0;
            lane_d     = '0;
        end

        // holding register is free if empty or being acked this cycle
        hold_free = !req_q || wr.wr_ack;
        load      = word_valid && hold_free;

        // addr_q is the address of the next word to load; advancing it on
        // load (dropped words never load) gives the same wr_addr sequence
        // as advancing on ack, including back-to-back loads in ack cycles
        req_d     = req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_be_d   = wr_be_q;
        addr_d    = addr_q;
        if (req_q && wr.wr_ack) begin
            req_d = 1'b0;
        end
        if (load) begin
            req_d     = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = word_data;
            wr_be_d   = word_be;
            addr_d    = addr_q + ADDR_WIDTH'(1);
        end
        if (ev_start) begin
            addr_d = ADDR_WIDTH'(START_ADDR);
        end

        overrun_d = overrun_q;
        if (ev_start) begin
            overrun_d = 1'b0;
        end else if (word_valid && !hold_free) begin
            overrun_d = 1'b1;
        end

        size_d = size_q;
        if (ev_start) begin
            size_d = '0;
        end else if (ev_data && (size_q != '1)) begin
            size_d = size_q + 24'd1;
        end

        index_d = ev_index ? rx_byte : index_q;

        // DRAIN holds downloading high until the final write is acked
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (ev_end) begin
                    state_d = (!word_valid && hold_free) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!req_q || (wr.wr_ack && !load)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = state_q;
        endcase
        if (ev_start) begin
            state_d = ST_ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            ss_meta_q  <= 1'b0;
            ss_sync_q  <= 1'b0;
            sdi_meta_q <= 1'b0;
            sdi_sync_q <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            cmd_q      <= '0;
            first_q    <= 1'b0;
            state_q    <= ST_IDLE;
            index_q    <= '0;
            size_q     <= '0;
            overrun_q  <= 1'b0;
            addr_q     <= '0;
            asm_q      <= '0;
            fill_q     <= '0;
            lane_q     <= '0;
            req_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
        end else begin
            sck_meta_q <= sck_meta_d;
            sck_sync_q <= sck_sync_d;
            sck_prev_q <= sck_prev_d;
            ss_meta_q  <= ss_meta_d;
            ss_sync_q  <= ss_sync_d;
            sdi_meta_q <= sdi_meta_d;
            sdi_sync_q <= sdi_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            cmd_q      <= cmd_d;
            first_q    <= first_d;
            state_q    <= state_d;
            index_q    <= index_d;
            size_q     <= size_d;
            overrun_q  <= overrun_d;
            addr_q     <= addr_d;
            asm_q      <= asm_d;
            fill_q     <= fill_d;
            lane_q     <= lane_d;
            req_q      <= req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
        end
    end

    assign downloading = (state_q != ST_IDLE);
    assign index       = index_q;
    assign size        = size_q;
    assign overrun     = overrun_q;
    assign wr.wr_req   = req_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign wr.wr_be    = wr_be_q;
endmodule

// File: tb/tb_data_io_dma.sv
// Bench for data_io_dma: three instances (8-bit @0x100, 16-bit @0x20,
// 8-bit with 4-bit address @0xE) share one SPI stream, reset and wr_ack.
// Accepted writes are logged per instance and checked against directed
// expectations.
module tb_data_io_dma;
    logic clk = 1'b0;
    logic reset, sck, ss, sdi, ack;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    data_io_dma_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8))  if8 ();
    data_io_dma_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) if16 ();
    data_io_dma_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(8))  if4 ();
    assign if8.wr_ack  = ack;
    assign if16.wr_ack = ack;
    assign if4.wr_ack  = ack;

    logic        dl8, dl16, dl4, ov8, ov16, ov4;
    logic [7:0]  idx8, idx16, idx4;
    logic [23:0] sz8, sz16, sz4;

    data_io_dma #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .START_ADDR(16'h100)) u8 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl8), .index(idx8), .size(sz8), .overrun(ov8), .wr(if8));
    data_io_dma #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .START_ADDR(16'h20)) u16 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl16), .index(idx16), .size(sz16), .overrun(ov16), .wr(if16));
    data_io_dma #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .START_ADDR(14)) u4 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl4), .index(idx4), .size(sz4), .overrun(ov4), .wr(if4));

    logic [63:0] q8[$], q16[$], q4[$];

    function automatic logic [63:0] wrd(input logic [15:0] a, input logic [15:0] d,
                                        input logic [3:0] b);
        return {28'h0, a, d, b};
    endfunction

    always @(posedge clk) begin
        if (if8.wr_req && if8.wr_ack)
            q8.push_back(wrd(16'(if8.wr_addr), 16'(if8.wr_data), 4'(if8.wr_be)));
        if (if16.wr_req && if16.wr_ack)
            q16.push_back(wrd(16'(if16.wr_addr), 16'(if16.wr_data), 4'(if16.wr_be)));
        if (if4.wr_req && if4.wr_ack)
            q4.push_back(wrd(16'(if4.wr_addr), 16'(if4.wr_data), 4'(if4.wr_be)));
    end

    function automatic logic [63:0] pick8(input int i);
        return (i < q8.size()) ? q8[i] : '1;
    endfunction
    function automatic logic [63:0] pick16(input int i);
        return (i < q16.size()) ? q16[i] : '1;
    endfunction
    function automatic logic [63:0] pick4(input int i);
        return (i < q4.size()) ? q4[i] : '1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        sdi = b;
        repeat (2) @(negedge clk);
        sck = 1'b1;
        repeat (2) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic spi_open(input logic [7:0] cmd);
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(cmd);
    endtask

    task automatic spi_close();
        repeat (4) @(negedge clk);
        ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic clear_logs();
        q8.delete();
        q16.delete();
        q4.delete();
    endtask

    initial begin
        reset = 1'b1; sck = 1'b0; ss = 1'b1; sdi = 1'b0; ack = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // reset state
        chk("rst_dl",   64'(dl8), 64'd0);
        chk("rst_req",  64'(if8.wr_req), 64'd0);
        chk("rst_size", 64'(sz8), 64'd0);
        chk("rst_idx",  64'(idx8), 64'd0);
        chk("rst_ov",   64'(ov8), 64'd0);

        // full-word download, 4 bytes, ack tied high
        spi_open(8'h53); spi_byte(8'h01); spi_close();
        chk("t1_dl_on", 64'(dl8), 64'd1);
        spi_open(8'h54);
        spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_byte(8'h44);
        spi_close();
        spi_open(8'h53); spi_byte(8'h00); spi_close();
        chk("t1_n8",   64'(q8.size()), 64'd4);
        chk("t1_w8_0", pick8(0), wrd(16'h100, 16'h11, 4'h1));
        chk("t1_w8_3", pick8(3), wrd(16'h103, 16'h44, 4'h1));
        chk("t1_n16",  64'(q16.size()), 64'd2);
        chk("t1_w16_0", pick16(0), wrd(16'h20, 16'h2211, 4'h3));
        chk("t1_w16_1", pick16(1), wrd(16'h21, 16'h4433, 4'h3));
        chk("t1_w4_0", pick4(0), wrd(16'hE, 16'h11, 4'h1));
        chk("t1_w4_1", pick4(1), wrd(16'hF, 16'h22, 4'h1));
        chk("t1_w4_2", pick4(2), wrd(16'h0, 16'h33, 4'h1));
        chk("t1_w4_3", pick4(3), wrd(16'h1, 16'h44, 4'h1));
        chk("t1_size", 64'(sz16), 64'd4);
        chk("t1_dl_off", 64'({dl8, dl16, dl4}), 64'd0);
        clear_logs();

        // odd byte count: 16-bit instance flushes a partial word
        spi_open(8'h53); spi_byte(8'h01); spi_close();
        spi_open(8'h54); spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_close();
        spi_open(8'h53); spi_byte(8'h00); spi_close();
        chk("t2_n16",   64'(q16.size()), 64'd2);
        chk("t2_w16_0", pick16(0), wrd(16'h20, 16'h2211, 4'h3));
        chk("t2_w16_1", pick16(1), wrd(16'h21, 16'h0033, 4'h1));
        chk("t2_w8_2",  pick8(2), wrd(16'h102, 16'h33, 4'h1));
        chk("t2_size",  64'(sz16), 64'd3);
        chk("t2_dl_off", 64'(dl16), 64'd0);
        clear_logs();

        // file index, then data while not downloading is ignored
        spi_open(8'h55); spi_byte(8'h07); spi_close();
        chk("t3_idx", 64'(idx8), 64'h07);
        spi_open(8'h54); spi_byte(8'hAA); spi_byte(8'hBB); spi_close();
        chk("t3_nwr",  64'(q8.size() + q16.size() + q4.size()), 64'd0);
        chk("t3_req",  64'(if8.wr_req), 64'd0);
        chk("t3_size", 64'(sz8), 64'd3);

        // back-pressure: ack held low across several completed words
        ack = 1'b0;
        spi_open(8'h53); spi_byte(8'h01); spi_close();
        spi_open(8'h54);
        spi_byte(8'h5A); spi_byte(8'h6B); spi_byte(8'h7C); spi_byte(8'h8D);
        spi_close();
        chk("t4_req8",  64'(if8.wr_req), 64'd1);
        chk("t4_addr8", 64'(if8.wr_addr), 64'h100);
        chk("t4_data8", 64'(if8.wr_data), 64'h5A);
        chk("t4_data16", 64'(if16.wr_data), 64'h6B5A);
        chk("t4_addr4", 64'(if4.wr_addr), 64'hE);
        chk("t4_ov", 64'({ov8, ov16, ov4}), 64'h7);
        spi_open(8'h53); spi_byte(8'h00); spi_close();
        chk("t4_drain_dl", 64'(dl8), 64'd1);
        chk("t4_size", 64'(sz8), 64'd4);
        ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_n8",   64'(q8.size()), 64'd1);
        chk("t4_w8",   pick8(0), wrd(16'h100, 16'h5A, 4'h1));
        chk("t4_w16",  pick16(0), wrd(16'h20, 16'h6B5A, 4'h3));
        chk("t4_dl_off", 64'({dl8, dl16, dl4}), 64'd0);
        chk("t4_ov_sticky", 64'(ov8), 64'd1);
        spi_open(8'h53); spi_byte(8'h01); spi_close();
        chk("t4_ov_clr", 64'(ov8), 64'd0);
        chk("t4_size_clr", 64'(sz8), 64'd0);

        // asynchronous reset with a write pending
        ack = 1'b0;
        spi_open(8'h54); spi_byte(8'h99); spi_close();
        chk("t5_req_pre", 64'(if8.wr_req), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_req",  64'(if8.wr_req), 64'd0);
        chk("t5_addr", 64'(if8.wr_addr), 64'd0);
        chk("t5_data", 64'(if8.wr_data), 64'd0);
        chk("t5_dl",   64'(dl8), 64'd0);
        chk("t5_size", 64'(sz8), 64'd0);
        chk("t5_idx",  64'(idx8), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ack = 1'b1;
        clear_logs();
        repeat (4) @(negedge clk);
        spi_open(8'h53); spi_byte(8'h01); spi_close();
        spi_open(8'h54); spi_byte(8'hE7); spi_close();
        spi_open(8'h53); spi_byte(8'h00); spi_close();
        chk("t5_w8", pick8(0), wrd(16'h100, 16'hE7, 4'h1));
        chk("t5_w4", pick4(0), wrd(16'hE, 16'hE7, 4'h1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
